// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty flags,
// an occupancy count, sticky overflow/underflow errors, and an optional
// first-word-fall-through read path. Depth need not be a power of two.
module fifo_sync_prog #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [FIFO_WIDTH-1:0]           data_in,
  input  logic                            rd_en,
  input  logic                            clr_err,
  output logic [FIFO_WIDTH-1:0]           data_out,
  output logic                            rd_valid,
  output logic                            empty,
  output logic                            full,
  output logic                            almost_empty,
  output logic                            almost_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            overflow,
  output logic                            underflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          almost_full_q, almost_full_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          rd_acc;
  logic          wr_acc;

  // Accept decisions, pointer/count advance and next-state flags.
  always_comb begin
    // NOTE: every signal gets a default at the top so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;

    rd_acc = rd_en & ~empty_q;
    // A full FIFO still takes a write when the same cycle pops a word.
    wr_acc = wr_en & (~full_q | rd_acc);

    if (wr_acc) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Flags are registered from the next count so they line up with it.
    empty_d        = (count_d == '0);
    full_d         = (count_d == DEPTH_C);
    almost_empty_d = (count_d <= AE_C);
    almost_full_d  = (count_d >= AF_C);

    // A new error in the same cycle as clr_err keeps the flag set.
    overflow_d  = (wr_en & ~wr_acc) | (overflow_q & ~clr_err);
    underflow_d = (rd_en & empty_q) | (underflow_q & ~clr_err);
  end

  // Control state: pointers, count, flags and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_empty_q <= 1'b1;
      almost_full_q  <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_empty_q <= almost_empty_d;
      almost_full_q  <= almost_full_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; empty/count already mark its
    // contents invalid, and leaving it unreset lets it map onto RAM.
    if (wr_acc) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented continuously; zero while nothing is stored.
      assign data_out = empty_q ? '0 : mem[rd_ptr_q];
      assign rd_valid = ~empty_q;
    end else begin : g_std
      logic [FIFO_WIDTH-1:0] data_out_q, data_out_d;
      logic                  rd_valid_q, rd_valid_d;

      // Registered read: capture the head on an accepted read, else hold.
      always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
          data_out_d = mem[rd_ptr_q];
        end
      end

      // Read data register with one-cycle latency.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data_out_q <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          data_out_q <= data_out_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign data_out = data_out_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = almost_empty_q;
  assign almost_full  = almost_full_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Bench for fifo_sync_prog: three instances (standard depth 16, FWFT depth 16,
// standard depth 5) share one stimulus stream and are each compared every
// cycle against a queue-based model, plus hand-computed literal expectations.
module tb_fifo_sync_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] dout_w [3];
  logic       rv_w   [3];
  logic       emp_w  [3];
  logic       full_w [3];
  logic       ae_w   [3];
  logic       af_w   [3];
  logic       ovf_w  [3];
  logic       udf_w  [3];
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Per-instance configuration.
  int D   [3] = '{16, 16, 5};
  int AFT [3] = '{12, 12, 4};
  int AET [3] = '{2, 2, 1};
  int FW  [3] = '{0, 1, 0};

  // Behavioural model state.
  logic [7:0] q [3][$];
  logic [7:0] m_dout [3];
  logic       m_rv   [3];
  logic       m_ovf  [3];
  logic       m_udf  [3];

  always #5 clk = ~clk;

  fifo_sync_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout_w[0]), .rd_valid(rv_w[0]), .empty(emp_w[0]), .full(full_w[0]),
    .almost_empty(ae_w[0]), .almost_full(af_w[0]), .count(cnt0),
    .overflow(ovf_w[0]), .underflow(udf_w[0]));

  fifo_sync_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(16), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout_w[1]), .rd_valid(rv_w[1]), .empty(emp_w[1]), .full(full_w[1]),
    .almost_empty(ae_w[1]), .almost_full(af_w[1]), .count(cnt1),
    .overflow(ovf_w[1]), .underflow(udf_w[1]));

  fifo_sync_prog #(.FIFO_WIDTH(8), .FIFO_DEPTH(5), .AF_THRESH(4), .AE_THRESH(1), .FWFT(0)) u_d5 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(dout_w[2]), .rd_valid(rv_w[2]), .empty(emp_w[2]), .full(full_w[2]),
    .almost_empty(ae_w[2]), .almost_full(af_w[2]), .count(cnt2),
    .overflow(ovf_w[2]), .underflow(udf_w[2]));

  function automatic int cnt_of(input int i);
    if (i == 0) return int'(cnt0);
    if (i == 1) return int'(cnt1);
    return int'(cnt2);
  endfunction

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", name, inst, $time, act, exp);
    end
  endtask

  // Reference model: FIFO as a queue, updated from pre-edge inputs.
  always @(posedge clk or posedge rst) begin
    int n;
    bit ra, wa;
    logic [7:0] pd;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        q[i].delete();
        m_dout[i] = '0;
        m_rv[i]   = 1'b0;
        m_ovf[i]  = 1'b0;
        m_udf[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        n  = q[i].size();
        ra = rd_en && (n > 0);
        wa = wr_en && ((n < D[i]) || ra);
        pd = '0;
        if (ra) pd = q[i].pop_front();
        if (wa) q[i].push_back(data_in);
        if (FW[i] == 0) begin
          m_rv[i] = ra;
          if (ra) m_dout[i] = pd;
        end
        if (wr_en && !wa) m_ovf[i] = 1'b1;
        else if (clr_err) m_ovf[i] = 1'b0;
        if (rd_en && (n == 0)) m_udf[i] = 1'b1;
        else if (clr_err) m_udf[i] = 1'b0;
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    int n;
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        n = q[i].size();
        check("count", i, cnt_of(i), n);
        check("empty", i, emp_w[i], n == 0);
        check("full", i, full_w[i], n == D[i]);
        check("almost_empty", i, ae_w[i], n <= AET[i]);
        check("almost_full", i, af_w[i], n >= AFT[i]);
        check("overflow", i, ovf_w[i], m_ovf[i]);
        check("underflow", i, udf_w[i], m_udf[i]);
        if (FW[i] != 0) begin
          check("rd_valid", i, rv_w[i], n > 0);
          if (n > 0) check("data_out", i, dout_w[i], q[i][0]);
        end else begin
          check("rd_valid", i, rv_w[i], m_rv[i]);
          check("data_out", i, dout_w[i], m_dout[i]);
        end
      end
    end
  end

  // One clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic step(input bit wr, input logic [7:0] din, input bit rd, input bit clr);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Reset values.
    check("rst_count", 0, cnt0, 0);
    check("rst_empty", 0, emp_w[0], 1);
    check("rst_full", 0, full_w[0], 0);
    check("rst_ae", 0, ae_w[0], 1);
    check("rst_af", 0, af_w[0], 0);
    check("rst_dout", 0, dout_w[0], 0);
    check("rst_rv", 0, rv_w[0], 0);
    check("rst_ovf", 0, ovf_w[0], 0);
    check("rst_udf", 0, udf_w[0], 0);

    // Fill with 0x01..0x10.
    for (int k = 1; k <= 16; k++) begin
      step(1, 8'(k), 0, 0);
      if (k == 2)  check("ae_at_2", 0, ae_w[0], 1);
      if (k == 3)  check("ae_at_3", 0, ae_w[0], 0);
      if (k == 11) check("af_at_11", 0, af_w[0], 0);
      if (k == 12) check("af_at_12", 0, af_w[0], 1);
    end
    check("fill_full", 0, full_w[0], 1);
    check("fill_count", 0, cnt0, 16);
    check("fill_ovf", 0, ovf_w[0], 0);

    // 17th write is dropped.
    step(1, 8'h11, 0, 0);
    check("ovf_set", 0, ovf_w[0], 1);
    check("ovf_count", 0, cnt0, 16);
    step(0, 0, 0, 1);
    check("ovf_clr", 0, ovf_w[0], 0);

    // Full with simultaneous write/read.
    step(1, 8'hAA, 1, 0);
    check("wr_rd_full_count", 0, cnt0, 16);
    check("wr_rd_full_full", 0, full_w[0], 1);
    check("wr_rd_full_ovf", 0, ovf_w[0], 0);
    check("wr_rd_full_dout", 0, dout_w[0], 8'h01);
    for (int k = 0; k < 16; k++) step(0, 0, 1, 0);
    check("last_is_aa", 0, dout_w[0], 8'hAA);
    check("drained_empty", 0, emp_w[0], 1);

    // Underflow on empty read, then clear.
    step(0, 0, 1, 0);
    check("udf_set", 0, udf_w[0], 1);
    check("udf_rv", 0, rv_w[0], 0);
    step(0, 0, 0, 1);
    check("udf_clr", 0, udf_w[0], 0);

    // Empty with simultaneous write 0x55 and read.
    step(1, 8'h55, 1, 0);
    check("wr_rd_empty_count", 0, cnt0, 1);
    check("wr_rd_empty_udf", 0, udf_w[0], 1);
    check("fwft_dout_55", 1, dout_w[1], 8'h55);
    check("fwft_rv_55", 1, rv_w[1], 1);
    step(0, 0, 1, 0);
    check("std_dout_55", 0, dout_w[0], 8'h55);
    check("std_rv_55", 0, rv_w[0], 1);
    step(0, 0, 0, 1);

    // Back-to-back push/pop of 12 words; depth-5 pointers wrap.
    step(1, 8'h20, 0, 0);
    for (int k = 1; k < 12; k++) begin
      step(1, 8'(8'h20 + k), 1, 0);
      check("wrap_count_le1", 2, cnt2 <= 3'd1, 1);
      check("wrap_order", 2, dout_w[2], 8'(8'h20 + k - 1));
    end
    step(0, 0, 1, 0);
    check("wrap_last", 2, dout_w[2], 8'h2B);
    check("wrap_empty", 2, emp_w[2], 1);

    // Randomized traffic: write-heavy, then read-heavy, then balanced.
    for (int k = 0; k < 450; k++) begin
      int wp, rp;
      wp = (k < 150) ? 80 : (k < 300) ? 25 : 55;
      rp = (k < 150) ? 25 : (k < 300) ? 80 : 50;
      step($urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp, $urandom_range(99) < 5);
    end

    // Drain, then build count 7 and reset asynchronously mid-burst.
    for (int k = 0; k < 17; k++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(1, 8'(8'h60 + k), 0, 0);
    check("pre_rst_count", 0, cnt0, 7);
    wr_en   = 1'b1;
    data_in = 8'h99;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", 0, cnt0, 0);
    check("async_rst_empty", 0, emp_w[0], 1);
    check("async_rst_ae", 0, ae_w[0], 1);
    check("async_rst_dout", 0, dout_w[0], 0);
    check("async_rst_rv", 0, rv_w[0], 0);
    check("async_rst_fwft_rv", 1, rv_w[1], 0);
    check("async_rst_count5", 2, cnt2, 0);
    wr_en = 1'b0;
    #1;
    rst = 1'b0;
    step(1, 8'h77, 0, 0);
    step(1, 8'h88, 0, 0);
    check("post_rst_fwft_head", 1, dout_w[1], 8'h77);
    step(0, 0, 1, 0);
    check("post_rst_first", 0, dout_w[0], 8'h77);
    step(0, 0, 1, 0);
    check("post_rst_second", 0, dout_w[0], 8'h88);
    step(0, 0, 0, 0);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
